// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_scheduler
// Brief    : Round-robin arbiter holding a registered one-hot grant until
//            done, owner request drop, or hold-time limit, then rotating.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 64
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [WIDTH-1:0]         req_i,
  input  logic                     done_i,
  output logic [WIDTH-1:0]         gnt_o,
  output logic [$clog2(WIDTH)-1:0] gnt_idx_o,
  output logic                     gnt_val_o,
  output logic                     timeout_o
);

  localparam int IDX_W = $clog2(WIDTH);
  // A zero-width counter is illegal, so keep one bit when the timeout is off.
  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] c_last_rst  = IDX_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic [IDX_W-1:0] r_last_idx, w_last_idx_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [IDX_W-1:0] w_base;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_hi_lsb;
  logic [WIDTH-1:0] w_req_lsb;
  logic [WIDTH-1:0] w_pick;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_owner_req;
  logic             w_hold_expired;
  logic             w_rel;

  // Search starts just above the previous owner; fallback wraps to bit 0.
  assign w_base = (r_state == ST_GRANT) ? r_gnt_idx : r_last_idx;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_mask[i] = (i > int'(w_base));
    end
  end

  assign w_hi      = req_i & w_mask;
  assign w_hi_lsb  = w_hi & (~w_hi + 1'b1);
  assign w_req_lsb = req_i & (~req_i + 1'b1);
  assign w_pick    = (w_hi != '0) ? w_hi_lsb : w_req_lsb;

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_pick[i]) w_pick_idx = w_pick_idx | IDX_W'(i);
    end
  end

  assign w_owner_req    = req_i[r_gnt_idx];
  assign w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);
  assign w_rel          = done_i || !w_owner_req || w_hold_expired;

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_last_idx_nxt = r_last_idx;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req_i != '0) begin
          w_gnt_nxt      = w_pick;
          w_gnt_idx_nxt  = w_pick_idx;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_rel) begin
          w_last_idx_nxt = r_gnt_idx;
          w_timeout_nxt  = w_hold_expired && !done_i && w_owner_req;
          w_hold_cnt_nxt = '0;
          if (req_i != '0) begin
            w_gnt_nxt     = w_pick;
            w_gnt_idx_nxt = w_pick_idx;
          end else begin
            w_gnt_nxt     = '0;
            w_gnt_idx_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_gnt_nxt     = '0;
        w_gnt_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_last_idx <= c_last_rst;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_idx_o = r_gnt_idx;
  assign gnt_val_o = (r_state == ST_GRANT);
  assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_scheduler
// Brief    : Directed self-checking bench for rr_grant_scheduler (WIDTH=4, MAX_HOLD=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_scheduler;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 8;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [WIDTH-1:0] req_i;
  logic             done_i;
  logic [WIDTH-1:0] gnt_o;
  logic [1:0]       gnt_idx_o;
  logic             gnt_val_o;
  logic             timeout_o;

  int checks = 0;
  int errors = 0;

  rr_grant_scheduler #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .req_i     (req_i),
    .done_i    (done_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .gnt_val_o (gnt_val_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] e_gnt,
                       input logic [1:0] e_idx, input logic e_val, input logic e_to);
    checks++;
    assert (gnt_o === e_gnt) else begin
      errors++;
      $error("FAIL %s gnt_o observed=%b expected=%b", tag, gnt_o, e_gnt);
    end
    checks++;
    assert (gnt_idx_o === e_idx) else begin
      errors++;
      $error("FAIL %s gnt_idx_o observed=%0d expected=%0d", tag, gnt_idx_o, e_idx);
    end
    checks++;
    assert (gnt_val_o === e_val) else begin
      errors++;
      $error("FAIL %s gnt_val_o observed=%b expected=%b", tag, gnt_val_o, e_val);
    end
    checks++;
    assert (timeout_o === e_to) else begin
      errors++;
      $error("FAIL %s timeout_o observed=%b expected=%b", tag, timeout_o, e_to);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    srst_i = 1'b1;
    req_i  = '0;
    done_i = 1'b0;
    tick();
    tick();
    srst_i = 1'b0;
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 1: basic grant, rotation and wrap
    req_i = 4'b1010;
    tick();
    check("t1_first", 4'b0010, 2'd1, 1'b1, 1'b0);
    done_i = 1'b1;
    tick();
    check("t1_rotate", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    check("t1_wrap", 4'b0010, 2'd1, 1'b1, 1'b0);
    done_i = 1'b0;

    // 2: full request, done every cycle
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    req_i  = 4'b1111;
    done_i = 1'b1;
    tick();
    check("t2_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check("t2_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    check("t2_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    check("t2_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    check("t2_g0b", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 3: single requester hits the hold limit twice
    done_i = 1'b0;
    req_i  = 4'b0100;
    tick();
    check("t3_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
      check("t3_hold_a", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    check("t3_timeout_a", 4'b0100, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
      check("t3_hold_b", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    check("t3_timeout_b", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick();
    check("t3_pulse_end", 4'b0100, 2'd2, 1'b1, 1'b0);

    // 4: owner drops request, idle ignores done
    req_i = 4'b0000;
    tick();
    check("t4_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    done_i = 1'b1;
    tick();
    check("t4_idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done_i = 1'b0;

    // 5: reset mid-grant restores last_idx
    req_i = 4'b1000;
    tick();
    check("t5_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    check("t5_hold3", 4'b1000, 2'd3, 1'b1, 1'b0);
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    check("t5_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_i = 4'b1001;
    tick();
    check("t5_after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 6: owner drop and done in the same cycle give one release
    req_i = 4'b0110;
    tick();
    check("t6_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_i  = 4'b0100;
    done_i = 1'b1;
    tick();
    check("t6_release", 4'b0100, 2'd2, 1'b1, 1'b0);
    done_i = 1'b0;
    tick();
    check("t6_hold", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin arbiter that shares one downstream resource between WIDTH requesters.
- Built on the same lowest-set-bit / one-hot search used by the team's priority encoders.
- Holds a registered one-hot grant until the owner signals done, drops its request, or exceeds a hold-time limit, then rotates priority.
- Sits between requester front-ends and a shared datapath port, bus master or lookup engine.

Parameters:
- WIDTH, 16, number of requesters; WIDTH >= 2.
- MAX_HOLD, 64, maximum cycles one grant may be held; 0 disables the timeout.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- srst_i  input  1  reset, synchronous, active-high.
- req_i  input  WIDTH  request vector; bit n is requester n.
- done_i  input  1  current owner finished; sampled only in GRANT.
- gnt_o  output  WIDTH  registered one-hot grant; all zero when idle.
- gnt_idx_o  output  $clog2(WIDTH)  binary index of the granted bit; 0 when idle.
- gnt_val_o  output  1  high while any grant is active.
- timeout_o  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (srst_i = 1), effective the following cycle:
  - gnt_o = 0, gnt_idx_o = 0, gnt_val_o = 0, timeout_o = 0.
  - state = IDLE, hold_cnt = 0, last_idx = WIDTH-1.
  - Reset overrides every other input, including mid-grant.
- Selection function sel(req, last):
  - hi = req with bits [last:0] cleared.
  - If hi != 0, pick the lowest set bit of hi; otherwise pick the lowest set bit of req.
  - Result is one-hot plus its index.
  - With last = WIDTH-1, hi is always 0, so the search starts at bit 0.
  - Combinational, no loops with break.
- State IDLE:
  - Outputs zero.
  - If req_i != 0: next cycle gnt_o = sel(req_i, last_idx), gnt_idx_o = its index, gnt_val_o = 1, hold_cnt = 0, state = GRANT.
  - Request-to-grant latency is 1 cycle.
- State GRANT, release conditions:
  - rel = done_i OR NOT req_i[gnt_idx_o] OR (MAX_HOLD != 0 AND hold_cnt == MAX_HOLD-1).
- State GRANT, if not rel: hold_cnt increments; grant is unchanged.
- State GRANT, if rel:
  - last_idx <= gnt_idx_o.
  - timeout_o <= 1 only if the timeout term is the sole cause (done_i = 0 and the owner still requesting).
  - If req_i != 0: next grant = sel(req_i, gnt_idx_o); back-to-back, no idle cycle; hold_cnt = 0; stay in GRANT.
  - If the owner is the only requester, it is re-granted; this is legal.
  - If req_i = 0: gnt_o = 0, gnt_val_o = 0, gnt_idx_o = 0; state = IDLE.
- Wrap-around: the search above index WIDTH-1 wraps to bit 0 through the fallback path.
- hold_cnt is $clog2(MAX_HOLD+1) bits and never exceeds MAX_HOLD-1.
- req_i bits for non-owners may toggle freely during a grant; only the owner's bit affects release.
- done_i in IDLE is ignored.
- timeout_o is 0 on every cycle except the one following a timeout release.
- gnt_o is always one-hot or zero; gnt_idx_o always matches gnt_o.

Test Plan (WIDTH=4, MAX_HOLD=8):
1. Reset, then req_i=1010 -> next cycle gnt_o=0010, gnt_idx_o=1, gnt_val_o=1. Hold req, pulse done_i -> gnt_o=1000, idx 3. Pulse done_i -> gnt_o=0010 (wrap).
2. req_i=1111, done_i=1 every cycle -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; gnt_val_o stays 1.
3. req_i=0100 held, done_i=0 -> gnt_o=0100 for 8 cycles; timeout_o=1 on the cycle after the 8th; gnt_o stays 0100 with hold_cnt restarted; next timeout 8 cycles later.
4. Grant on bit 2, owner drops req_i to 0000 -> next cycle gnt_o=0000, gnt_val_o=0, state IDLE; done_i=1 while idle -> no change.
5. Grant on bit 3 mid-hold, assert srst_i one cycle -> all outputs 0; then req_i=1001 -> gnt_o=0001 (last_idx reset to WIDTH-1).
6. Owner bit 1 granted, req_i=0110; owner drops its bit the same cycle done_i=1 -> single release, gnt_o=0100, timeout_o=0.
